// File: rtl/cache_axi_pkg.sv
// ============================================================================
// Module      : cache_axi_pkg
// Description : Shared encodings and default widths for the cache read
//               arbiter: FSM states, owner codes and default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_axi_pkg;

  localparam int c_DEF_ADDR_WIDTH   = 32;
  localparam int c_DEF_DATA_WIDTH   = 32;
  localparam int c_DEF_STARVE_LIMIT = 4;

  // Arbiter sequencing: pick a winner, present its address, stream its beats
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Which requester currently owns the memory port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_DC   = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/read_arb_pick.sv
// ============================================================================
// Module      : read_arb_pick
// Description : Combinational winner selection between the instruction and
//               data cache requesters. Data side normally wins; the
//               instruction side wins once it has been starved long enough.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_arb_pick (
  input  logic ic_valid,
  input  logic dc_valid,
  input  logic starve_hit,
  output logic grant_ic,
  output logic grant_dc
);

  // Instruction side wins only when alone or when its starvation count is full
  assign grant_ic = ic_valid & (~dc_valid | starve_hit);
  assign grant_dc = dc_valid & ~grant_ic;

endmodule

`default_nettype wire

// File: rtl/cache_read_arbiter.sv
// ============================================================================
// Module      : cache_read_arbiter
// Description : Two-requester read arbiter (instruction cache, data cache)
//               sharing one memory read port. One burst in flight at a time;
//               the address phase is registered, the data phase is routed
//               combinationally to the current owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_read_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ADDR_WIDTH   = c_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = c_DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction cache
  input  logic [ADDR_WIDTH-1:0] ic_araddr,
  input  logic                  ic_arvalid,
  output logic                  ic_arready,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_rvalid,
  output logic                  ic_rlast,
  input  logic                  ic_rready,
  // data cache
  input  logic [ADDR_WIDTH-1:0] dc_araddr,
  input  logic                  dc_arvalid,
  output logic                  dc_arready,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_rvalid,
  output logic                  dc_rlast,
  input  logic                  dc_rready,
  // memory
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  output logic                  m_rready
);

  // Counter must be able to hold STARVE_LIMIT itself; keep at least one bit
  localparam int                 c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  owner_t                r_owner;
  owner_t                w_owner_nxt;
  logic [c_CNT_W-1:0]    r_starve_cnt;
  logic [c_CNT_W-1:0]    w_starve_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [ADDR_WIDTH-1:0] w_araddr_nxt;

  logic w_starve_hit;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_in_addr;
  logic w_in_data;
  logic w_own_ic;
  logic w_own_dc;
  logic w_last_beat;

  assign w_starve_hit = (r_starve_cnt == c_LIMIT);
  assign w_in_addr    = (r_state == ST_ADDR);
  assign w_in_data    = (r_state == ST_DATA);
  assign w_own_ic     = (r_owner == OWN_IC);
  assign w_own_dc     = (r_owner == OWN_DC);
  assign w_last_beat  = m_rvalid & m_rready & m_rlast;

  read_arb_pick u_pick (
    .ic_valid   (ic_arvalid),
    .dc_valid   (dc_arvalid),
    .starve_hit (w_starve_hit),
    .grant_ic   (w_grant_ic),
    .grant_dc   (w_grant_dc)
  );

  // State, owner, starvation count and latched address; reset abandons any burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
      r_araddr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_araddr     <= w_araddr_nxt;
    end
  end

  // Next-state: grant in IDLE, wait for address accept, run until the last beat
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;
    w_araddr_nxt = r_araddr;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_ic) begin
          w_state_nxt  = ST_ADDR;
          w_owner_nxt  = OWN_IC;
          w_araddr_nxt = ic_araddr;
          w_starve_nxt = '0;
        end else if (w_grant_dc) begin
          w_state_nxt  = ST_ADDR;
          w_owner_nxt  = OWN_DC;
          w_araddr_nxt = dc_araddr;
          if (!w_starve_hit) begin
            w_starve_nxt = r_starve_cnt + c_ONE;
          end
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_last_beat) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Address phase is driven purely from registered state
  assign m_araddr   = r_araddr;
  assign m_arvalid  = w_in_addr;
  assign ic_arready = w_in_addr & w_own_ic & m_arready;
  assign dc_arready = w_in_addr & w_own_dc & m_arready;

  // Data phase: owner sees memory beats, memory sees owner's back-pressure
  assign m_rready  = w_in_data & ((w_own_ic & ic_rready) | (w_own_dc & dc_rready));
  assign ic_rvalid = w_in_data & w_own_ic & m_rvalid;
  assign ic_rlast  = w_in_data & w_own_ic & m_rlast;
  assign ic_rdata  = (w_in_data & w_own_ic) ? m_rdata : '0;
  assign dc_rvalid = w_in_data & w_own_dc & m_rvalid;
  assign dc_rlast  = w_in_data & w_own_dc & m_rlast;
  assign dc_rdata  = (w_in_data & w_own_dc) ? m_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_read_arbiter.sv
// ============================================================================
// Module      : tb_cache_read_arbiter
// Description : Self-checking bench for cache_read_arbiter with a behavioural
//               memory, two requester processes and beat scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cache_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ic_araddr, dc_araddr, m_araddr;
  logic          ic_arvalid, ic_arready, dc_arvalid, dc_arready;
  logic [DW-1:0] ic_rdata, dc_rdata, m_rdata;
  logic          ic_rvalid, ic_rlast, ic_rready;
  logic          dc_rvalid, dc_rlast, dc_rready;
  logic          m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;

  cache_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .ic_araddr(ic_araddr), .ic_arvalid(ic_arvalid), .ic_arready(ic_arready),
    .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast), .ic_rready(ic_rready),
    .dc_araddr(dc_araddr), .dc_arvalid(dc_arvalid), .dc_arready(dc_arready),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast), .dc_rready(dc_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // every DUT output bundled, for the reset checks
  wire [2*DW+7:0] all_outs = {m_arvalid, m_rready, ic_arready, ic_rvalid, ic_rlast, ic_rdata,
                              dc_arready, dc_rvalid, dc_rlast, dc_rdata};

  int tests_run = 0;
  int tests_failed = 0;
  int ar_delay = 1;
  int mem_beats = 8;
  bit stray_en = 0;
  int ic_beats = 0;
  int dc_beats = 0;
  int ic_arready_cycles = 0;
  bit dc_last_seen = 0;

  logic [AW-1:0] ic_reqs[$];
  logic [AW-1:0] dc_reqs[$];
  logic [DW:0]   ic_q[$];
  logic [DW:0]   dc_q[$];
  int            grant_log[$];

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
    return a + 32'h0001_0000 * 32'(i + 1);
  endfunction

  // scoreboard push happens together with the request
  task automatic issue_ic(input logic [AW-1:0] a);
    ic_reqs.push_back(a);
    for (int i = 0; i < mem_beats; i++) ic_q.push_back({(i == mem_beats - 1), beat_data(a, i)});
  endtask

  task automatic issue_dc(input logic [AW-1:0] a);
    dc_reqs.push_back(a);
    for (int i = 0; i < mem_beats; i++) dc_q.push_back({(i == mem_beats - 1), beat_data(a, i)});
  endtask

  // behavioural memory: sample at negedge, drive just after posedge
  initial begin : mem_model
    int mstate; int wait_cnt; int beat;
    logic [AW-1:0] base; logic [AW-1:0] s_addr;
    bit s_arv; bit s_arhs; bit s_rhs; bit s_rst;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0;
    mstate = 0; wait_cnt = 0; beat = 0; base = '0;
    forever begin
      @(negedge clk);
      s_arv = m_arvalid; s_arhs = m_arvalid && m_arready; s_rhs = m_rvalid && m_rready;
      s_addr = m_araddr; s_rst = rst;
      @(posedge clk); #1;
      if (!s_rst || !rst) begin
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; mstate = 0; wait_cnt = 0;
      end else begin
        case (mstate)
          0: begin
            m_rvalid = stray_en; m_rlast = stray_en; m_rdata = stray_en ? 32'hDEAD_BEEF : '0;
            if (s_arv) begin
              wait_cnt++;
              if (wait_cnt >= ar_delay) begin m_arready = 1; mstate = 1; end
            end
          end
          1: begin
            if (s_arhs) begin
              m_arready = 0; wait_cnt = 0; base = s_addr; beat = 0;
              m_rvalid = 1; m_rdata = beat_data(base, 0); m_rlast = (mem_beats == 1); mstate = 2;
            end else begin
              m_rvalid = stray_en; m_rlast = stray_en; m_rdata = stray_en ? 32'hDEAD_BEEF : '0;
            end
          end
          default: begin
            if (s_rhs) begin
              beat++;
              if (beat == mem_beats) begin
                m_rvalid = 0; m_rlast = 0; m_rdata = '0; mstate = 0;
              end else begin
                m_rdata = beat_data(base, beat); m_rlast = (beat == mem_beats - 1);
              end
            end
          end
        endcase
      end
    end
  end

  initial begin : ic_requester
    bit s_rdy;
    ic_arvalid = 0; ic_araddr = '0;
    forever begin
      @(negedge clk); s_rdy = ic_arready;
      @(posedge clk); #1;
      if (ic_arvalid && s_rdy) ic_arvalid = 0;
      if (!ic_arvalid && ic_reqs.size() > 0) begin ic_araddr = ic_reqs.pop_front(); ic_arvalid = 1; end
    end
  end

  initial begin : dc_requester
    bit s_rdy;
    dc_arvalid = 0; dc_araddr = '0;
    forever begin
      @(negedge clk); s_rdy = dc_arready;
      @(posedge clk); #1;
      if (dc_arvalid && s_rdy) dc_arvalid = 0;
      if (!dc_arvalid && dc_reqs.size() > 0) begin dc_araddr = dc_reqs.pop_front(); dc_arvalid = 1; end
    end
  end

  // beat scoreboards and per-cycle protocol checks
  initial begin : monitor
    logic [DW:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ic_rvalid) begin
          tests_run++;
          if (ic_q.size() == 0) begin
            tests_failed++;
            $display("FAIL ic_unexpected_beat: got rvalid=1 rdata=%h, expected no beat", ic_rdata);
          end else if (ic_rready) begin
            exp = ic_q.pop_front();
            if ({ic_rlast, ic_rdata} !== exp)  begin
              tests_failed++;
              $display("FAIL ic_beat: got last=%b data=%h, expected last=%b data=%h", ic_rlast, ic_rdata, exp[DW], exp[DW-1:0]);
            end
            ic_beats++;
          end
        end else begin
          tests_run++;
          if (ic_rdata !== '0 || ic_rlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL ic_idle_rdata: got rdata=%h rlast=%b, expected 0", ic_rdata, ic_rlast);
          end
        end
        if (dc_rvalid) begin
          tests_run++;
          if (dc_q.size() == 0) begin
            tests_failed++;
            $display("FAIL dc_unexpected_beat: got rvalid=1 rdata=%h, expected no beat", dc_rdata);
          end else if (dc_rready) begin
            exp = dc_q.pop_front();
            if ({dc_rlast, dc_rdata} !== exp) begin
              tests_failed++;
              $display("FAIL dc_beat: got last=%b data=%h, expected last=%b data=%h", dc_rlast, dc_rdata, exp[DW], exp[DW-1:0]);
            end
            dc_beats++;
            if (dc_rlast) dc_last_seen = 1;
          end
        end else begin
          tests_run++;
          if (dc_rdata !== '0 || dc_rlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL dc_idle_rdata: got rdata=%h rlast=%b, expected 0", dc_rdata, dc_rlast);
          end
        end
        if (ic_arready) begin
          grant_log.push_back(1); ic_arready_cycles++; tests_run++;
          if (!(m_arvalid && m_arready && ic_arvalid && dc_arready === 1'b0 && m_araddr === ic_araddr)) begin
            tests_failed++;
            $display("FAIL ic_ar_handshake: got m_arvalid=%b m_arready=%b dc_arready=%b m_araddr=%h, expected 1/1/0/%h",
                     m_arvalid, m_arready, dc_arready, m_araddr, ic_araddr);
          end
        end
        if (dc_arready) begin
          grant_log.push_back(2); tests_run++;
          if (!(m_arvalid && m_arready && dc_arvalid && ic_arready === 1'b0 && m_araddr === dc_araddr)) begin
            tests_failed++;
            $display("FAIL dc_ar_handshake: got m_arvalid=%b m_arready=%b ic_arready=%b m_araddr=%h, expected 1/1/0/%h",
                     m_arvalid, m_arready, ic_arready, m_araddr, dc_araddr);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 0;
    ic_arvalid = 0; dc_arvalid = 0;
    ic_reqs.delete(); dc_reqs.delete(); ic_q.delete(); dc_q.delete(); grant_log.delete();
    ar_delay = 1; mem_beats = 8; stray_en = 0; ic_rready = 1; dc_rready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1;
    ic_beats = 0; dc_beats = 0; ic_arready_cycles = 0; dc_last_seen = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ic_q.size() == 0 && dc_q.size() == 0 && ic_reqs.size() == 0 && dc_reqs.size() == 0 &&
          !ic_arvalid && !dc_arvalid) begin
        done = 1;
        break;
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_timeout: got ic_q=%0d dc_q=%0d pending, expected 0", name, ic_q.size(), dc_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0; ic_rready = 1; dc_rready = 1;
    ic_araddr = 32'h1111_0000; dc_araddr = 32'h2222_0000; ic_arvalid = 1; dc_arvalid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (all_outs !== '0 || m_araddr !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got outs=%h m_araddr=%h, expected 0", all_outs, m_araddr);
      end
    end
    do_reset();
    @(negedge clk);
    tests_run++;
    if (m_arvalid !== 1'b0 || m_araddr !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got m_arvalid=%b m_araddr=%h, expected 0/0", m_arvalid, m_araddr);
    end
  endtask

  task automatic test_ic_only();
    do_reset();
    issue_ic(32'h8000_0040);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (ic_arvalid) break; end
    tests_run++;
    if (m_arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ic_only_req_cycle: got m_arvalid=%b, expected 0", m_arvalid);
    end
    @(negedge clk);
    tests_run++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0040) begin
      tests_failed++;
      $display("FAIL ic_only_latency: got m_arvalid=%b m_araddr=%h, expected 1/80000040", m_arvalid, m_araddr);
    end
    wait_done(60, "ic_only");
    tests_run++;
    if (ic_beats != 8 || dc_beats != 0 || grant_log.size() != 1) begin
      tests_failed++;
      $display("FAIL ic_only_counts: got ic=%0d dc=%0d grants=%0d, expected 8/0/1", ic_beats, dc_beats, grant_log.size());
    end
  endtask

  task automatic test_priority();
    do_reset();
    mem_beats = 4;
    issue_dc(32'h9000_0000);
    issue_ic(32'h8000_0000);
    for (int i = 0; i < 60; i++) begin @(negedge clk); #1; if (dc_last_seen) break; end
    tests_run++;
    if (!dc_last_seen) begin
      tests_failed++;
      $display("FAIL priority_dc_last: got none, expected dc rlast");
    end
    @(negedge clk);
    tests_run++;
    if (m_arvalid !== 1'b0 || ic_arvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL priority_bubble: got m_arvalid=%b ic_arvalid=%b, expected 0/1", m_arvalid, ic_arvalid);
    end
    @(negedge clk);
    tests_run++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL priority_ic_grant: got m_arvalid=%b m_araddr=%h, expected 1/80000000", m_arvalid, m_araddr);
    end
    wait_done(60, "priority");
    tests_run++;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 1) begin
      tests_failed++;
      $display("FAIL priority_order: got %0d grants first=%0d, expected DC then IC", grant_log.size(),
               (grant_log.size() > 0) ? grant_log[0] : 0);
    end
  endtask

  task automatic test_starvation();
    int exp_g[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    do_reset();
    mem_beats = 2;
    for (int i = 0; i < 8; i++) issue_dc(32'hA000_0000 + 32'(i) * 32'h100);
    issue_ic(32'h8000_1000);
    issue_ic(32'h8000_2000);
    wait_done(400, "starvation");
    tests_run++;
    if (grant_log.size() != 10) begin
      tests_failed++;
      $display("FAIL starve_grant_count: got %0d, expected 10", grant_log.size());
    end
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      tests_run++;
      if (grant_log[i] != exp_g[i]) begin
        tests_failed++;
        $display("FAIL starve_grant_%0d: got %0d, expected %0d (1=IC 2=DC)", i, grant_log[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    issue_ic(32'h8000_0100);
    for (int i = 0; i < 60; i++) begin @(negedge clk); #1; if (ic_beats >= 2) break; end
    @(posedge clk); #1;
    ic_rready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (m_rready !== 1'b0 || ic_rvalid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cycle_%0d: got m_rready=%b ic_rvalid=%b, expected 0/1", i, m_rready, ic_rvalid);
      end
    end
    @(posedge clk); #1;
    ic_rready = 1;
    wait_done(60, "backpressure");
    tests_run++;
    if (ic_beats != 8) begin
      tests_failed++;
      $display("FAIL stall_beats: got %0d, expected 8", ic_beats);
    end
  endtask

  task automatic test_ar_delay();
    int n_hi; int n_low;
    do_reset();
    ar_delay = 5; mem_beats = 2;
    issue_ic(32'h8000_0200);
    n_hi = 0; n_low = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_arvalid) break; end
    for (int i = 0; i < 20; i++) begin
      if (!m_arvalid) break;
      tests_run++;
      if (m_araddr !== 32'h8000_0200) begin
        tests_failed++;
        $display("FAIL ar_hold_addr: got %h, expected 80000200", m_araddr);
      end
      n_hi++;
      if (!m_arready) n_low++;
      @(negedge clk);
    end
    wait_done(60, "ar_delay");
    tests_run++;
    if (n_hi != 6 || n_low != 5 || ic_arready_cycles != 1) begin
      tests_failed++;
      $display("FAIL ar_delay_cycles: got arvalid=%0d waiting=%0d arready=%0d, expected 6/5/1", n_hi, n_low, ic_arready_cycles);
    end
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    stray_en = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (m_rready !== 1'b0 || ic_rvalid !== 1'b0 || dc_rvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stray_idle: got m_rready=%b ic_rvalid=%b dc_rvalid=%b, expected 0/0/0", m_rready, ic_rvalid, dc_rvalid);
      end
    end
    ar_delay = 3; mem_beats = 4;
    issue_dc(32'hB000_0000);
    wait_done(60, "stray");
    stray_en = 0;
    tests_run++;
    if (dc_beats != 4) begin
      tests_failed++;
      $display("FAIL stray_beats: got %0d, expected 4", dc_beats);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    issue_ic(32'h8000_0300);
    for (int i = 0; i < 60; i++) begin @(negedge clk); #1; if (ic_beats >= 3) break; end
    tests_run++;
    if (ic_beats != 3) begin
      tests_failed++;
      $display("FAIL midrst_reach_beat3: got %0d beats, expected 3", ic_beats);
    end
    rst = 0;
    #1;
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++;
      $display("FAIL midrst_async_outputs: got %h, expected 0", all_outs);
    end
    ic_arvalid = 0; dc_arvalid = 0;
    ic_reqs.delete(); dc_reqs.delete(); ic_q.delete(); dc_q.delete(); grant_log.delete();
    repeat (2) @(negedge clk);
    tests_run++;
    if (all_outs !== '0 || m_araddr !== '0) begin
      tests_failed++;
      $display("FAIL midrst_hold: got outs=%h m_araddr=%h, expected 0", all_outs, m_araddr);
    end
    #1;
    rst = 1;
    ic_beats = 0; dc_beats = 0; dc_last_seen = 0;
    mem_beats = 4;
    issue_dc(32'hA000_0400);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (dc_arvalid) break; end
    @(negedge clk);
    tests_run++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'hA000_0400) begin
      tests_failed++;
      $display("FAIL midrst_new_grant: got m_arvalid=%b m_araddr=%h, expected 1/a0000400", m_arvalid, m_araddr);
    end
    wait_done(60, "midrst");
    tests_run++;
    if (dc_beats != 4 || ic_beats != 0 || grant_log.size() != 1) begin
      tests_failed++;
      $display("FAIL midrst_after: got dc=%0d ic=%0d grants=%0d, expected 4/0/1", dc_beats, ic_beats, grant_log.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst = 0; ic_rready = 1; dc_rready = 1;
    test_reset();
    test_ic_only();
    test_priority();
    test_starvation();
    test_backpressure();
    test_ar_delay();
    test_stray_rvalid();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
